// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer and its BCD helpers.
package alarm_pkg;
   typedef enum logic [2:0] {IDLE, SET_HOUR, SET_MIN, RINGING, SNOOZE} alm_state_e;
   typedef logic [7:0] bcd2_t;
   localparam bcd2_t BCD_HOUR_MAX = 8'h23;
   localparam bcd2_t BCD_MIN_MAX  = 8'h59;
endpackage

// File: rtl/alarm_bcd2_inc.sv
// Two-digit BCD incrementer that wraps to 00 once the value reaches MAX.
module bcd2_inc
   import alarm_pkg::*;
#(
   parameter bcd2_t MAX = BCD_MIN_MAX
) (
   input  logic [7:0] i_bcd,
   output logic [7:0] o_bcd
);
   always_comb begin
      if (i_bcd == MAX)
         o_bcd = 8'h00;
      else if (i_bcd[3:0] == 4'd9)
         o_bcd = {i_bcd[7:4] + 4'd1, 4'd0};
      else
         o_bcd = {i_bcd[7:4], i_bcd[3:0] + 4'd1};
   end
endmodule

// File: rtl/alarm_sequencer.sv
// Alarm controller: holds the BCD alarm time, runs button-driven editing and
// sequences the ring / snooze cycle with a gated buzzer tone.
module alarm_sequencer
   import alarm_pkg::*;
#(
   parameter logic [7:0] ALM_RST_H  = 8'h06,
   parameter logic [7:0] ALM_RST_M  = 8'h30,
   parameter int         RING_SECS  = 60,
   parameter int         SNOOZE_MIN = 5,
   parameter int         EDIT_TO    = 10,
   parameter int         TONE_DIV   = 4
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        tick_1hz,
   input  logic        btn_set,
   input  logic        btn_inc,
   input  logic        btn_snooze,
   input  logic        alarm_en,
   input  logic [15:0] cur_time,
   input  logic        cur_sec_zero,
   output logic [15:0] alm_time,
   output logic        edit_hour,
   output logic        edit_min,
   output logic        ringing,
   output logic        snoozing,
   output logic        buzzer
);
   localparam int            TW          = $clog2(TONE_DIV) + 1;
   localparam logic [9:0]    SNOOZE_LOAD = 10'(SNOOZE_MIN * 60);
   localparam logic [7:0]    RING_LAST   = 8'(RING_SECS - 1);
   localparam logic [5:0]    EDIT_LAST   = 6'(EDIT_TO - 1);
   localparam logic [TW-1:0] TONE_LAST   = TW'(TONE_DIV - 1);

   alm_state_e    r_state;
   logic [7:0]    r_alm_h, r_alm_m;
   logic [5:0]    r_edit_cnt;
   logic [7:0]    r_ring_cnt;
   logic [9:0]    r_snooze_cnt;
   logic [TW-1:0] r_tone_div;
   logic          r_tone;
   logic          r_edit_hour, r_edit_min, r_ringing, r_snoozing, r_buzzer;

   alm_state_e    w_state_next;
   logic [7:0]    w_alm_h_next, w_alm_m_next;
   logic [5:0]    w_edit_cnt_next;
   logic [7:0]    w_ring_cnt_next;
   logic [9:0]    w_snooze_cnt_next;
   logic [TW-1:0] w_tone_div_next;
   logic          w_tone_next;
   logic [7:0]    w_hour_inc, w_min_inc;
   logic          w_any_btn, w_match;

   bcd2_inc #(.MAX(BCD_HOUR_MAX)) u_hour_inc (.i_bcd(r_alm_h), .o_bcd(w_hour_inc));
   bcd2_inc #(.MAX(BCD_MIN_MAX))  u_min_inc  (.i_bcd(r_alm_m), .o_bcd(w_min_inc));

   assign w_any_btn = btn_set | btn_inc | btn_snooze;
   assign w_match   = alarm_en & tick_1hz & cur_sec_zero & (cur_time == {r_alm_h, r_alm_m});

   always_comb begin
      w_state_next      = r_state;
      w_alm_h_next      = r_alm_h;
      w_alm_m_next      = r_alm_m;
      w_edit_cnt_next   = r_edit_cnt;
      w_ring_cnt_next   = r_ring_cnt;
      w_snooze_cnt_next = r_snooze_cnt;
      w_tone_div_next   = r_tone_div;
      w_tone_next       = r_tone;
      case (r_state)
         IDLE: begin
            if (btn_set) begin
               w_state_next    = SET_HOUR;
               w_edit_cnt_next = 6'd0;
            end else if (w_match) begin
               w_state_next    = RINGING;
               w_ring_cnt_next = 8'd0;
               w_tone_div_next = '0;
               w_tone_next     = 1'b0;
            end
         end
         SET_HOUR, SET_MIN: begin
            if (w_any_btn)
               w_edit_cnt_next = 6'd0;
            if (btn_set) begin
               w_state_next = (r_state == SET_HOUR) ? SET_MIN : IDLE;
            end else if (btn_inc && !btn_snooze) begin
               if (r_state == SET_HOUR)
                  w_alm_h_next = w_hour_inc;
               else
                  w_alm_m_next = w_min_inc;
            end else if (tick_1hz && !btn_snooze) begin
               w_edit_cnt_next = r_edit_cnt + 6'd1;
               if (r_edit_cnt == EDIT_LAST)
                  w_state_next = IDLE;
            end
         end
         RINGING: begin
            if (btn_set || !alarm_en) begin
               w_state_next = IDLE;
            end else if (btn_snooze) begin
               w_state_next      = SNOOZE;
               w_snooze_cnt_next = SNOOZE_LOAD;
            end else begin
               // Tone keeps running across second boundaries; ring_cnt[0] only gates it.
               if (r_tone_div == TONE_LAST) begin
                  w_tone_div_next = '0;
                  w_tone_next     = ~r_tone;
               end else begin
                  w_tone_div_next = r_tone_div + 1'b1;
               end
               if (tick_1hz) begin
                  if (r_ring_cnt == RING_LAST)
                     w_state_next = IDLE;
                  else
                     w_ring_cnt_next = r_ring_cnt + 8'd1;
               end
            end
         end
         SNOOZE: begin
            if (btn_set || !alarm_en) begin
               w_state_next = IDLE;
            end else if (tick_1hz) begin
               if (r_snooze_cnt == 10'd1) begin
                  w_state_next    = RINGING;
                  w_ring_cnt_next = 8'd0;
                  w_tone_div_next = '0;
                  w_tone_next     = 1'b0;
               end else begin
                  w_snooze_cnt_next = r_snooze_cnt - 10'd1;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Flags are registered from the next state so they track the state register exactly.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_alm_h      <= ALM_RST_H;
         r_alm_m      <= ALM_RST_M;
         r_edit_cnt   <= 6'd0;
         r_ring_cnt   <= 8'd0;
         r_snooze_cnt <= 10'd0;
         r_tone_div   <= '0;
         r_tone       <= 1'b0;
         r_edit_hour  <= 1'b0;
         r_edit_min   <= 1'b0;
         r_ringing    <= 1'b0;
         r_snoozing   <= 1'b0;
         r_buzzer     <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_alm_h      <= w_alm_h_next;
         r_alm_m      <= w_alm_m_next;
         r_edit_cnt   <= w_edit_cnt_next;
         r_ring_cnt   <= w_ring_cnt_next;
         r_snooze_cnt <= w_snooze_cnt_next;
         r_tone_div   <= w_tone_div_next;
         r_tone       <= w_tone_next;
         r_edit_hour  <= (w_state_next == SET_HOUR);
         r_edit_min   <= (w_state_next == SET_MIN);
         r_ringing    <= (w_state_next == RINGING);
         r_snoozing   <= (w_state_next == SNOOZE);
         r_buzzer     <= (w_state_next == RINGING) && !w_ring_cnt_next[0] && w_tone_next;
      end
   end

   assign alm_time  = {r_alm_h, r_alm_m};
   assign edit_hour = r_edit_hour;
   assign edit_min  = r_edit_min;
   assign ringing   = r_ringing;
   assign snoozing  = r_snoozing;
   assign buzzer    = r_buzzer;
endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: a vector table, hand-built ring/snooze/edit sequences,
// then random stimulus compared against an integer-arithmetic model of the alarm rules.
module tb_alarm_sequencer;
   localparam int TD = 4, RS = 60, SM = 1, ET = 10;
   localparam int S_IDLE = 0, S_HOUR = 1, S_MIN = 2, S_RING = 3, S_SNZ = 4;

   logic        clk_in = 1'b0;
   logic        reset = 1'b1;
   logic        tick_1hz = 1'b0, btn_set = 1'b0, btn_inc = 1'b0, btn_snooze = 1'b0;
   logic        alarm_en = 1'b0, cur_sec_zero = 1'b0;
   logic [15:0] cur_time = 16'h0000;
   logic [15:0] alm_time;
   logic        edit_hour, edit_min, ringing, snoozing, buzzer;

   int n_chk = 0, n_pass = 0;
   int m_st, m_h, m_m, m_edt, m_ring, m_snz, m_nt;

   alarm_sequencer #(
      .ALM_RST_H(8'h06), .ALM_RST_M(8'h30), .RING_SECS(RS),
      .SNOOZE_MIN(SM), .EDIT_TO(ET), .TONE_DIV(TD)
   ) dut (
      .clk_in(clk_in), .reset(reset), .tick_1hz(tick_1hz), .btn_set(btn_set),
      .btn_inc(btn_inc), .btn_snooze(btn_snooze), .alarm_en(alarm_en),
      .cur_time(cur_time), .cur_sec_zero(cur_sec_zero), .alm_time(alm_time),
      .edit_hour(edit_hour), .edit_min(edit_min), .ringing(ringing),
      .snoozing(snoozing), .buzzer(buzzer)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic s, i, z, t, en, sz;
      logic [15:0] ct;
      logic [15:0] e_alm;
      logic [4:0]  e_flg;
   } vec_t;

   function automatic logic [7:0] bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   function automatic logic [15:0] m_alm();
      return {bcd(m_h), bcd(m_m)};
   endfunction

   function automatic logic [4:0] m_flags();
      logic bz;
      bz = (m_st == S_RING) && (m_ring % 2 == 0) && ((m_nt / TD) % 2 == 1);
      return {m_st == S_HOUR, m_st == S_MIN, m_st == S_RING, m_st == S_SNZ, bz};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic expect_out(input string name, input logic [15:0] e_alm, input logic [4:0] e_flg);
      check({name, "_alm"}, alm_time, e_alm);
      check({name, "_flags"}, {11'd0, edit_hour, edit_min, ringing, snoozing, buzzer}, {11'd0, e_flg});
      $display("%s: alm=%h flags=%b", name, alm_time, {edit_hour, edit_min, ringing, snoozing, buzzer});
   endtask

   task automatic model_reset();
      m_st = S_IDLE; m_h = 6; m_m = 30; m_edt = 0; m_ring = 0; m_snz = 0; m_nt = 0;
   endtask

   task automatic model_step(input logic s, input logic i, input logic z, input logic t);
      logic match;
      match = alarm_en && t && cur_sec_zero && (cur_time == m_alm());
      case (m_st)
         S_IDLE: begin
            if (s) begin m_st = S_HOUR; m_edt = 0; end
            else if (match) begin m_st = S_RING; m_ring = 0; m_nt = 0; end
         end
         S_HOUR, S_MIN: begin
            if (s || i || z) m_edt = 0;
            if (s) m_st = (m_st == S_HOUR) ? S_MIN : S_IDLE;
            else if (i && !z) begin
               if (m_st == S_HOUR) m_h = (m_h + 1) % 24;
               else m_m = (m_m + 1) % 60;
            end else if (t && !z) begin
               m_edt++;
               if (m_edt >= ET) m_st = S_IDLE;
            end
         end
         S_RING: begin
            if (s || !alarm_en) m_st = S_IDLE;
            else if (z) begin m_st = S_SNZ; m_snz = SM * 60; end
            else begin
               m_nt++;
               if (t) begin
                  if (m_ring == RS - 1) m_st = S_IDLE;
                  else m_ring++;
               end
            end
         end
         S_SNZ: begin
            if (s || !alarm_en) m_st = S_IDLE;
            else if (t) begin
               if (m_snz == 1) begin m_st = S_RING; m_ring = 0; m_nt = 0; end
               else m_snz--;
            end
         end
         default: m_st = S_IDLE;
      endcase
   endtask

   // Drive one cycle of pulses, then sample 1 time unit after the rising edge.
   task automatic step(input logic s, input logic i, input logic z, input logic t);
      btn_set = s; btn_inc = i; btn_snooze = z; tick_1hz = t;
      @(posedge clk_in); #1;
      model_step(s, i, z, t);
      btn_set = 1'b0; btn_inc = 1'b0; btn_snooze = 1'b0; tick_1hz = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk_in); #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic start_ring(input string name);
      alarm_en = 1'b1; cur_time = 16'h0630; cur_sec_zero = 1'b1;
      step(0, 0, 0, 1);
      cur_sec_zero = 1'b0;
      expect_out(name, 16'h0630, 5'b00100);
   endtask

   vec_t tbl[13];

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0630, 5'b10000};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0730, 5'b10000};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0730, 5'b10000};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0730, 5'b01000};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0731, 5'b01000};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0731, 5'b00000};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0731, 16'h0731, 5'b00100};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0731, 16'h0731, 5'b00000};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0731, 16'h0731, 5'b00000};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0731, 16'h0731, 5'b00000};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0731, 16'h0731, 5'b10000};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0731, 5'b01000};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0731, 5'b00000};

      // Reset state, with and without idle cycles.
      #1;
      repeat (2) @(posedge clk_in);
      #1;
      reset = 1'b0;
      model_reset();
      expect_out("reset", 16'h0630, 5'b00000);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      expect_out("reset_idle", 16'h0630, 5'b00000);

      for (int k = 0; k < 13; k++) begin
         alarm_en = tbl[k].en; cur_time = tbl[k].ct; cur_sec_zero = tbl[k].sz;
         step(tbl[k].s, tbl[k].i, tbl[k].z, tbl[k].t);
         expect_out($sformatf("vec%0d", k), tbl[k].e_alm, tbl[k].e_flg);
      end
      cur_sec_zero = 1'b0;

      // Hour edit wraps 23 -> 00.
      do_reset();
      step(1, 0, 0, 0);
      for (int k = 0; k < 18; k++) step(0, 1, 0, 0);
      expect_out("hour_wrap", 16'h0030, 5'b10000);
      step(1, 0, 0, 0);
      expect_out("hour_to_min", 16'h0030, 5'b01000);
      step(1, 0, 0, 0);
      expect_out("hour_exit", 16'h0030, 5'b00000);

      // Minute edit wraps 59 -> 00 without touching the hour, then times out.
      do_reset();
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      for (int k = 0; k < 30; k++) step(0, 1, 0, 0);
      expect_out("min_wrap", 16'h0600, 5'b01000);
      for (int k = 0; k < ET - 1; k++) step(0, 0, 0, 1);
      expect_out("edit_to_pre", 16'h0600, 5'b01000);
      step(0, 0, 0, 1);
      expect_out("edit_to", 16'h0600, 5'b00000);

      // Ring: buzzer tone in even second, silent in odd second, auto-dismiss.
      do_reset();
      start_ring("ring_start");
      for (int k = 1; k <= 12; k++) begin
         step(0, 0, 0, 0);
         check($sformatf("tone_k%0d", k), {15'd0, buzzer}, {15'd0, 1'((k / TD) % 2)});
      end
      step(0, 0, 0, 1);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("odd_sec_%0d", k), {15'd0, buzzer}, 16'd0);
         step(0, 0, 0, 0);
      end
      for (int k = 0; k < RS - 2; k++) step(0, 0, 0, 1);
      expect_out("ring_last_sec", 16'h0630, 5'b00100);
      step(0, 0, 0, 1);
      expect_out("ring_auto_off", 16'h0630, 5'b00000);

      // Snooze, re-ring, dismiss; then simultaneous set+snooze.
      do_reset();
      start_ring("snz_ring");
      step(0, 0, 1, 0);
      expect_out("snz_enter", 16'h0630, 5'b00010);
      for (int k = 0; k < SM * 60 - 1; k++) step(0, 0, 0, 1);
      step(0, 0, 1, 0);
      expect_out("snz_pre", 16'h0630, 5'b00010);
      step(0, 0, 0, 1);
      expect_out("snz_rering", 16'h0630, 5'b00100);
      step(1, 0, 0, 0);
      expect_out("snz_dismiss", 16'h0630, 5'b00000);
      start_ring("ring2");
      step(1, 0, 1, 0);
      expect_out("set_and_snz", 16'h0630, 5'b00000);

      // alarm_en dropped while snoozing.
      start_ring("ring3");
      step(0, 0, 1, 0);
      alarm_en = 1'b0;
      step(0, 0, 0, 0);
      expect_out("en_drop", 16'h0630, 5'b00000);
      alarm_en = 1'b1;

      // Asynchronous reset mid-ring, while the buzzer is high.
      start_ring("ring4");
      repeat (TD) step(0, 0, 0, 0);
      check("buzz_before_rst", {15'd0, buzzer}, 16'd1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_buzz", {15'd0, buzzer}, 16'd0);
      check("async_rst_ring", {15'd0, ringing}, 16'd0);
      @(posedge clk_in); #1;
      reset = 1'b0;
      model_reset();

      // Random stimulus against the model.
      alarm_en = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         logic s, i, z, t;
         if ($urandom_range(0, 699) == 0) do_reset();
         if ($urandom_range(0, 299) == 0) alarm_en = ~alarm_en;
         cur_sec_zero = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) cur_time = m_alm();
         else cur_time = {bcd(int'($urandom_range(0, 23))), bcd(int'($urandom_range(0, 59)))};
         s = ($urandom_range(0, 79) == 0);
         z = ($urandom_range(0, 24) == 0);
         i = ($urandom_range(0, 9) == 0);
         t = ($urandom_range(0, 1) == 0);
         step(s, i, z, t);
         check($sformatf("rnd%0d_alm", c), alm_time, m_alm());
         check($sformatf("rnd%0d_flags", c), {11'd0, edit_hour, edit_min, ringing, snoozing, buzzer},
               {11'd0, m_flags()});
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
